// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Data-memory responder. Word RAM with byte-lane writes and
//               zero-latency reads. Defining DMEM_RESP_MMIO_EN adds an MMIO
//               window with a TX FIFO, GPIO register and cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int MEM_WORDS     = 1024,
    parameter int MMIO_BASE_BIT = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [3:0]  d_mem_wen,
    input  logic [31:0] d_mem_wdata,
    output logic [31:0] d_mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] gpio_out
);

    localparam int c_AW = $clog2(MEM_WORDS);

    logic [31:0]     r_mem [MEM_WORDS];
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_ram_rdata;
    logic            w_is_mmio;
    logic            w_ram_we;
    logic            w_unused_addr;

    // Only the index bits select a word; everything above them aliases.
    assign w_idx         = d_mem_addr[c_AW+1:2];
    assign w_ram_rdata   = r_mem[w_idx];
    assign w_ram_we      = (d_mem_wen != 4'b0000) && !w_is_mmio;
    assign w_unused_addr = ^d_mem_addr;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (d_mem_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_RESP_MMIO_EN
    localparam logic [1:0] c_OFS_TX     = 2'd0;
    localparam logic [1:0] c_OFS_STATUS = 2'd1;
    localparam logic [1:0] c_OFS_GPIO   = 2'd2;
    localparam logic [1:0] c_OFS_CYCLE  = 2'd3;

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic        r_overflow;
    logic [31:0] r_gpio;
    logic [31:0] r_cycle;

    logic [1:0]  w_ofs;
    logic        w_mmio_wr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_accept;
    logic [31:0] w_mmio_rdata;

    assign w_is_mmio = d_mem_addr[MMIO_BASE_BIT];
    assign w_ofs     = d_mem_addr[3:2];
    assign w_mmio_wr = w_is_mmio && (d_mem_wen != 4'b0000);
    assign w_empty   = (r_count == 3'd0);
    assign w_full    = (r_count == 3'd4);
    assign w_pop     = !w_empty && tx_ready;
    assign w_push    = w_is_mmio && (w_ofs == c_OFS_TX) && d_mem_wen[0];
    // When full, a same-cycle pop frees the head slot, which equals the tail.
    assign w_accept  = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_tail] <= d_mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
            r_gpio     <= 32'd0;
            r_cycle    <= 32'd0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 2'd1;
            end
            if (w_accept) begin
                r_tail <= r_tail + 2'd1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 3'd1;
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_mmio_wr && (w_ofs == c_OFS_GPIO)) begin
                for (int i = 0; i < 4; i++) begin
                    if (d_mem_wen[i]) begin
                        r_gpio[8*i +: 8] <= d_mem_wdata[8*i +: 8];
                    end
                end
            end
            if (w_mmio_wr && (w_ofs == c_OFS_CYCLE)) begin
                r_cycle <= 32'd0;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
        end
    end

    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_ofs)
            c_OFS_STATUS: w_mmio_rdata = {29'd0, r_overflow, w_full, w_empty};
            c_OFS_GPIO:   w_mmio_rdata = r_gpio;
            c_OFS_CYCLE:  w_mmio_rdata = r_cycle;
            default:      w_mmio_rdata = 32'd0;
        endcase
    end

    assign d_mem_data = w_is_mmio ? w_mmio_rdata : w_ram_rdata;
    assign tx_valid   = !w_empty;
    assign tx_data    = w_empty ? 8'd0 : r_fifo[r_head];
    assign gpio_out   = r_gpio;
`else
    logic w_unused_cfg;

    assign w_is_mmio    = 1'b0;
    assign w_unused_cfg = tx_ready ^ rst_n ^ d_mem_addr[MMIO_BASE_BIT];
    assign d_mem_data   = w_ram_rdata;
    assign tx_valid     = 1'b0;
    assign tx_data      = 8'd0;
    assign gpio_out     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Randomized self-checking bench for dmem_resp against a
//               word-array RAM model and a queue-based TX FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_mem_addr = 32'd0;
    logic [3:0]  d_mem_wen = 4'd0;
    logic [31:0] d_mem_wdata = 32'd0;
    logic [31:0] d_mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] gpio_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_mem [16];

    dmem_resp u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_mem_addr (d_mem_addr),
        .d_mem_wen  (d_mem_wen),
        .d_mem_wdata(d_mem_wdata),
        .d_mem_data (d_mem_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .gpio_out   (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        d_mem_addr  = a;
        d_mem_wen   = w;
        d_mem_wdata = d;
        @(posedge clk);
        #1;
        d_mem_wen = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        d_mem_addr = a;
        d_mem_wen  = 4'd0;
        #1;
        d = d_mem_data;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [3:0] w,
                                               input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Random alias of RAM word idx: random upper bits and byte offset, MMIO bit clear.
    function automatic logic [31:0] ram_alias(input int idx);
        logic [31:0] a;
        a = {$urandom} & 32'h7FFF_F003;
        a[11:2] = 10'(idx);
        return a;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        int          idx;

        repeat (2) @(negedge clk);
        #1;
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_gpio", gpio_out, 32'd0);
        rst_n = 1'b1;

        // Sub-word store merges into an earlier full-word store.
        bus_write(32'h0000_0010, 4'b1111, 32'h1122_3344);
        bus_write(32'h0000_0010, 4'b0100, 32'h00AA_0000);
        bus_read(32'h0000_0010, rd);
        check("byte_lane_merge", rd, 32'h11AA_3344);

        bus_write(32'h0000_0000, 4'b1111, 32'hDEAD_BEEF);
        bus_read(32'h0000_1000, rd);
        check("addr_wrap", rd, 32'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            m_mem[i] = $urandom;
            bus_write(ram_alias(i), 4'b1111, m_mem[i]);
        end

        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, 15);
            w   = 4'($urandom);
            d   = $urandom;
            tx_ready = 1'($urandom);
            bus_write(ram_alias(idx), w, d);
            m_mem[idx] = lane_merge(m_mem[idx], w, d);
            idx = $urandom_range(0, 15);
            bus_read(ram_alias(idx), rd);
            check("ram_random", rd, m_mem[idx]);
            if (n % 20 == 0) begin
                check("ram_phase_tx_valid", {31'd0, tx_valid}, 32'd0);
                check("ram_phase_tx_data", {24'd0, tx_data}, 32'd0);
                check("ram_phase_gpio", gpio_out, 32'd0);
            end
        end
        tx_ready = 1'b0;

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(ram_alias(5), rd);
        check("ram_after_reset", rd, m_mem[5]);

`ifndef DMEM_RESP_MMIO_EN
        bus_write(32'h8000_0008, 4'b1111, 32'h1234_5678);
        bus_read(32'h0000_0008, rd);
        check("no_mmio_alias", rd, 32'h1234_5678);
        check("no_mmio_gpio", gpio_out, 32'd0);
        tx_ready = 1'b1;
        bus_write(32'h8000_0000, 4'b0001, 32'h0000_0041);
        #1;
        check("no_mmio_tx_valid", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
`else
        begin
            logic [7:0] q[$];
            bit         ovf;
            bit         pop;
            bit         push;
            int         sz;
            int         op;

            bus_read(32'h8000_0004, rd);
            check("status_reset", rd, 32'h1);

            for (int k = 0; k < 5; k++) bus_write(32'h8000_0000, 4'b0001, 32'h41 + k);
            bus_read(32'h8000_0004, rd);
            check("status_full_ovf", rd, 32'h6);
            tx_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                #1;
                check("drain_data", {24'd0, tx_data}, 32'h41 + k);
                check("drain_valid", {31'd0, tx_valid}, 32'd1);
                @(negedge clk);
            end
            tx_ready = 1'b0;
            bus_read(32'h8000_0004, rd);
            check("status_empty_ovf", rd, 32'h5);

            bus_write(32'h8000_0008, 4'b0101, 32'hAABB_CCDD);
            check("gpio_lanes_a", gpio_out, 32'h00BB_00DD);
            bus_write(32'h8000_0008, 4'b1010, 32'h1122_3344);
            bus_read(32'h8000_0008, rd);
            check("gpio_lanes_b", rd, 32'h11BB_33DD);
            bus_read(32'h8000_0000, rd);
            check("txdata_reads_zero", rd, 32'd0);

            @(negedge clk);
            d_mem_addr  = 32'h8000_0000;
            d_mem_wen   = 4'b0001;
            d_mem_wdata = 32'h77;
            #1;
            check("no_bypass", {31'd0, tx_valid}, 32'd0);
            @(posedge clk);
            #1;
            d_mem_wen = 4'd0;
            check("push_visible", {24'd0, tx_data}, 32'h77);

            @(negedge clk);
            rst_n = 1'b0;
            d_mem_addr = 32'h8000_000C;
            #1;
            check("async_rst_gpio", gpio_out, 32'd0);
            check("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
            check("async_rst_cycle", d_mem_data, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            bus_read(32'h8000_000C, rd);
            check("cycle_first_edge", rd, 32'd1);
            bus_read(32'h8000_0004, rd);
            check("status_after_rst", rd, 32'h1);

            for (int k = 0; k < 4; k++) bus_write(32'h8000_0000, 4'b0001, 32'h10 + k);
            @(negedge clk);
            d_mem_addr  = 32'h8000_0000;
            d_mem_wen   = 4'b0001;
            d_mem_wdata = 32'h55;
            tx_ready    = 1'b1;
            @(posedge clk);
            #1;
            d_mem_wen = 4'd0;
            tx_ready  = 1'b0;
            bus_read(32'h8000_0004, rd);
            check("full_push_pop_status", rd, 32'h2);
            tx_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                #1;
                check("full_push_pop_order", {24'd0, tx_data}, (k == 3) ? 32'h55 : 32'h11 + k);
                @(negedge clk);
            end
            tx_ready = 1'b0;

            bus_write(32'h8000_000C, 4'b1000, 32'hFFFF_FFFF);
            repeat (3) @(posedge clk);
            bus_read(32'h8000_000C, rd);
            check("cycle_reload", rd, 32'd3);

            q.delete();
            ovf = 1'b0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                op = $urandom_range(0, 2);
                tx_ready = ($urandom_range(0, 2) == 0);
                d_mem_wen   = 4'($urandom);
                d_mem_wdata = $urandom;
                d_mem_addr  = (op == 0) ? 32'h8000_0000 : 32'h8000_0004;
                #1;
                sz = q.size();
                check("rand_tx_valid", {31'd0, tx_valid}, {31'd0, sz != 0});
                check("rand_tx_data", {24'd0, tx_data}, (sz != 0) ? {24'd0, q[0]} : 32'd0);
                if (op != 0)
                    check("rand_status", d_mem_data, {29'd0, ovf, sz == 4, sz == 0});
                pop  = (sz != 0) && tx_ready;
                push = (op == 0) && d_mem_wen[0];
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (sz < 4 || pop) q.push_back(d_mem_wdata[7:0]);
                    else ovf = 1'b1;
                end
                @(posedge clk);
            end
            @(negedge clk);
            d_mem_wen = 4'd0;
            tx_ready  = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
